// File: rtl/uart_tx_flex_if.sv
// TX FIFO side of the flexible UART transmitter.
// Carries push data/strobes, flush, and FIFO status back.
interface uart_tx_flex_if #(
  parameter int DATA_MAX   = 9,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_MAX-1:0]         data_i;
  logic                        write_i;
  logic                        flush_i;
  logic                        fifo_empty_o;
  logic                        fifo_full_o;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_o;
  logic                        overflow_o;

  modport master (
    output data_i, write_i, flush_i,
    input  fifo_empty_o, fifo_full_o,
    input  fifo_count_o, overflow_o
  );

  modport slave (
    input  data_i, write_i, flush_i,
    output fifo_empty_o, fifo_full_o,
    output fifo_count_o, overflow_o
  );
endinterface

// File: rtl/uart_tx_flex.sv
// UART transmitter: FWFT TX FIFO + frame serialiser with parity,
// CTS flow control and break. Ports: clk_i/rst_n_i, tick, config, bus, line.
module uart_tx_flex #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_MAX   = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int BREAK_BITS = 13
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          enable_i,
  input  logic          ov_baud_rt_i,
  input  logic [3:0]    data_width_i,
  input  logic [2:0]    parity_mode_i,
  input  logic          stop_bits_i,
  input  logic          stream_mode_i,
  input  logic          cts_n_i,
  input  logic          break_i,
  uart_tx_flex_if.slave bus,
  output logic          tx_o,
  output logic          tx_done_o,
  output logic          break_done_o,
  output logic          tx_idle_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(BREAK_BITS + DATA_MAX + 1);

  localparam logic [AW:0]   FULL_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TLAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST  = BW'(BREAK_BITS - 1);
  localparam logic [3:0]    WMAX   = 4'(DATA_MAX);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_e;

  state_e state_q, state_d;

  logic [DATA_MAX-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]         wr_q, rd_q, cnt;
  logic                empty, full, push, pop;
  logic                ovf_q;

  logic [TW-1:0]       tick_q;
  logic [BW-1:0]       bit_q;
  logic                hold_q;
  logic [DATA_MAX-1:0] sh_q;
  logic [3:0]          width_q, width_c;
  logic [2:0]          pmode_q;
  logic                stop2_q, par_q;
  logic                tick_end, has_par, pbit;

  logic line_c, done_c, bdone_c;
  logic tx_q, done_q, bdone_q;

  // ---------------- FIFO ----------------
  assign cnt   = wr_q - rd_q;
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_C);
  assign push  = bus.write_i && !bus.flush_i && !full;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AW-1:0]] <= bus.data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      // full is judged before any pop this cycle
      ovf_q <= bus.write_i && !bus.flush_i && full;
      if (bus.flush_i) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
      end
    end
  end

  assign bus.fifo_empty_o = empty;
  assign bus.fifo_full_o  = full;
  assign bus.fifo_count_o = cnt;
  assign bus.overflow_o   = ovf_q;

  // ---------------- config ----------------
  always_comb begin
    width_c = data_width_i;
    if (data_width_i < 4'd5)    width_c = 4'd5;
    else if (data_width_i > WMAX) width_c = WMAX;
  end

  assign tick_end = ov_baud_rt_i && (tick_q == TLAST);
  assign has_par  = (pmode_q >= 3'd1) && (pmode_q <= 3'd4);

  always_comb begin
    pbit = 1'b1;
    unique case (pmode_q)
      3'd1:    pbit = par_q;
      3'd2:    pbit = ~par_q;
      3'd3:    pbit = 1'b1;
      3'd4:    pbit = 1'b0;
      default: pbit = 1'b1;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    line_c  = 1'b1;
    done_c  = 1'b0;
    bdone_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (break_i) begin
          state_d = BREAK;
        end else if (!empty && enable_i && !cts_n_i) begin
          state_d = START;
          pop     = 1'b1;
        end
      end
      START: begin
        line_c = 1'b0;
        if (tick_end) state_d = DATA;
      end
      DATA: begin
        line_c = sh_q[0];
        if (tick_end && bit_q == BW'(width_q - 4'd1))
          state_d = has_par ? PARITY : STOP;
      end
      PARITY: begin
        line_c = pbit;
        if (tick_end) state_d = STOP;
      end
      STOP: begin
        line_c = 1'b1;
        if (tick_end && bit_q == BW'(stop2_q)) begin
          state_d = IDLE;
          done_c  = !stream_mode_i || empty;
        end
      end
      BREAK: begin
        line_c = hold_q;
        if (hold_q && !break_i) begin
          state_d = IDLE;
          bdone_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_q  <= '0;
      bit_q   <= '0;
      hold_q  <= 1'b0;
      sh_q    <= '0;
      width_q <= 4'd5;
      pmode_q <= 3'd0;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      if (state_q == IDLE) tick_q <= '0;
      else if (ov_baud_rt_i) tick_q <= tick_end ? '0 : tick_q + 1'b1;

      if (state_d != state_q)     bit_q <= '0;
      else if (tick_end && !hold_q) bit_q <= bit_q + 1'b1;

      // break low phase done: line released until break_i drops
      hold_q <= (state_q == BREAK) &&
                (hold_q || (tick_end && bit_q == BLAST));

      if (pop) begin
        sh_q    <= mem_q[rd_q[AW-1:0]];
        width_q <= width_c;
        pmode_q <= parity_mode_i;
        stop2_q <= stop_bits_i;
        par_q   <= 1'b0;
      end else if (state_q == DATA && tick_end) begin
        sh_q  <= {1'b0, sh_q[DATA_MAX-1:1]};
        par_q <= par_q ^ sh_q[0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      bdone_q <= 1'b0;
    end else begin
      tx_q    <= line_c;
      done_q  <= done_c;
      bdone_q <= bdone_c;
    end
  end

  assign tx_o         = tx_q;
  assign tx_done_o    = done_q;
  assign break_done_o = bdone_q;
  assign tx_idle_o    = (state_q == IDLE);
endmodule

// File: tb/tb_uart_tx_flex.sv
// Directed bench for uart_tx_flex: frames, parity, clamp, FIFO,
// stream mode, break, CTS/enable gating, flush and reset.
module tb_uart_tx_flex;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, ov, stop_bits, stream, cts_n, brk;
  logic [3:0] width;
  logic [2:0] pmode;
  logic       tx, done, bdone, idle;

  int vec = 0;
  int miss = 0;
  int div = 1;
  int bitc = 16;
  int dcnt = 0;
  int done_cnt = 0, bdone_cnt = 0, ovf_cnt = 0, idle_cnt = 0;

  uart_tx_flex_if #(.DATA_MAX(9), .FIFO_DEPTH(16)) bus ();

  uart_tx_flex #(
    .OVERSAMPLE(16), .DATA_MAX(9),
    .FIFO_DEPTH(16), .BREAK_BITS(13)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .enable_i(enable), .ov_baud_rt_i(ov),
    .data_width_i(width), .parity_mode_i(pmode),
    .stop_bits_i(stop_bits), .stream_mode_i(stream),
    .cts_n_i(cts_n), .break_i(brk),
    .bus(bus),
    .tx_o(tx), .tx_done_o(done),
    .break_done_o(bdone), .tx_idle_o(idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dcnt >= div - 1) begin
      ov = 1'b1;
      dcnt = 0;
    end else begin
      ov = 1'b0;
      dcnt++;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bdone) bdone_cnt++;
    if (bus.overflow_o) ovf_cnt++;
    if (idle) idle_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [8:0] d);
    @(negedge clk);
    bus.data_i  = d;
    bus.write_i = 1'b1;
    @(negedge clk);
    bus.write_i = 1'b0;
  endtask

  // v[i] = i-th bit after the start bit, sampled mid-bit
  task automatic recv(input int nbits, output logic [15:0] v);
    int n = 0;
    v = '0;
    while (tx !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", {31'd0, tx}, 32'd0);
    if (tx !== 1'b0) begin
      v = 'x;
      return;
    end
    repeat (bitc / 2) @(negedge clk);
    chk("start_bit", {31'd0, tx}, 32'd0);
    for (int i = 0; i < nbits; i++) begin
      repeat (bitc) @(negedge clk);
      v[i] = tx;
    end
  endtask

  task automatic cfg(input logic [3:0] w, input logic [2:0] p,
                     input logic s);
    width = w;
    pmode = p;
    stop_bits = s;
  endtask

  logic [15:0] v;
  int d0, i0, n;

  initial begin
    rst_n = 1'b0;
    enable = 1'b1; cts_n = 1'b0; brk = 1'b0; stream = 1'b0;
    cfg(4'd8, 3'd0, 1'b0);
    bus.data_i = '0; bus.write_i = 1'b0; bus.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_empty", {31'd0, bus.fifo_empty_o}, 32'd1);
    chk("rst_full", {31'd0, bus.fifo_full_o}, 32'd0);
    chk("rst_count", 32'(bus.fifo_count_o), 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow_o}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bdone", {31'd0, bdone}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // latency and basic 8N1 frame
    d0 = done_cnt;
    bus.data_i = 9'h0A5; bus.write_i = 1'b1;
    @(negedge clk);
    bus.write_i = 1'b0;
    chk("lat_empty", {31'd0, bus.fifo_empty_o}, 32'd0);
    chk("lat_idle", {31'd0, idle}, 32'd1);
    @(negedge clk);
    chk("lat_start", {31'd0, idle}, 32'd0);
    chk("lat_tx_hi", {31'd0, tx}, 32'd1);
    @(negedge clk);
    chk("lat_tx_lo", {31'd0, tx}, 32'd0);
    recv(9, v);
    chk("frame_a5", 32'(v), 32'h1A5);
    repeat (bitc) @(negedge clk);
    chk("done_a5", 32'(done_cnt - d0), 32'd1);

    // 7O2 at half tick rate; config changed mid-frame
    div = 2; bitc = 32;
    cfg(4'd7, 3'd2, 1'b1);
    wr(9'h083);
    repeat (2) @(negedge clk);
    cfg(4'd8, 3'd0, 1'b0);
    recv(10, v);
    chk("frame_7o2", 32'(v), 32'h383);
    repeat (2 * bitc) @(negedge clk);
    div = 1; bitc = 16;

    // width clamp low, even parity
    cfg(4'd2, 3'd1, 1'b0);
    wr(9'h015);
    recv(7, v);
    chk("clamp_lo_even", 32'(v), 32'h075);
    repeat (bitc) @(negedge clk);

    // width clamp high, mark parity
    cfg(4'd15, 3'd3, 1'b0);
    wr(9'h0AA);
    recv(11, v);
    chk("clamp_hi_mark", 32'(v), 32'h6AA);
    repeat (bitc) @(negedge clk);

    // space parity
    cfg(4'd8, 3'd4, 1'b0);
    wr(9'h0FF);
    recv(10, v);
    chk("space_par", 32'(v), 32'h2FF);
    repeat (bitc) @(negedge clk);

    // overflow: 17 writes with CTS held off
    cfg(4'd8, 3'd0, 1'b0);
    cts_n = 1'b1;
    d0 = ovf_cnt;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      bus.data_i = 9'(9'h030 + i); bus.write_i = 1'b1;
      @(negedge clk);
    end
    bus.write_i = 1'b0;
    @(negedge clk);
    chk("ovf_count", 32'(bus.fifo_count_o), 32'd16);
    chk("ovf_full", {31'd0, bus.fifo_full_o}, 32'd1);
    chk("ovf_pulse", 32'(ovf_cnt - d0), 32'd1);
    cts_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      recv(9, v);
      chk("ovf_frame", 32'(v), 32'h100 | 32'(8'h30 + i));
    end
    repeat (3 * bitc) @(negedge clk);
    chk("ovf_no17_idle", {31'd0, idle}, 32'd1);
    chk("ovf_no17_empty", {31'd0, bus.fifo_empty_o}, 32'd1);

    // stream mode: three back-to-back frames, one done
    stream = 1'b1; cts_n = 1'b1;
    wr(9'h061); wr(9'h062); wr(9'h063);
    d0 = done_cnt;
    cts_n = 1'b0;
    recv(9, v);
    chk("strm_f1", 32'(v), 32'h161);
    i0 = idle_cnt;
    recv(9, v);
    chk("strm_f2", 32'(v), 32'h162);
    recv(9, v);
    chk("strm_f3", 32'(v), 32'h163);
    chk("strm_gap", 32'(idle_cnt - i0), 32'd2);
    repeat (bitc) @(negedge clk);
    chk("strm_done", 32'(done_cnt - d0), 32'd1);
    stream = 1'b0;

    // break with two words queued
    cts_n = 1'b1;
    wr(9'h011); wr(9'h022);
    d0 = bdone_cnt;
    brk = 1'b1; cts_n = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (tx === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("brk_low", 32'(n), 32'd208);
    repeat (30) @(negedge clk);
    chk("brk_hold_tx", {31'd0, tx}, 32'd1);
    chk("brk_hold_state", {31'd0, idle}, 32'd0);
    chk("brk_no_done", 32'(bdone_cnt - d0), 32'd0);
    brk = 1'b0;
    repeat (3) @(negedge clk);
    chk("brk_done", 32'(bdone_cnt - d0), 32'd1);
    recv(9, v);
    chk("brk_f1", 32'(v), 32'h111);
    recv(9, v);
    chk("brk_f2", 32'(v), 32'h122);
    repeat (bitc) @(negedge clk);

    // CTS dropped during frame 1 of 2
    @(negedge clk);
    bus.data_i = 9'h05A; bus.write_i = 1'b1;
    @(negedge clk);
    bus.data_i = 9'h0C3;
    @(negedge clk);
    bus.write_i = 1'b0;
    cts_n = 1'b1;
    recv(9, v);
    chk("cts_f1", 32'(v), 32'h15A);
    repeat (40) @(negedge clk);
    chk("cts_hold_tx", {31'd0, tx}, 32'd1);
    chk("cts_hold_idle", {31'd0, idle}, 32'd1);
    chk("cts_hold_cnt", 32'(bus.fifo_count_o), 32'd1);
    cts_n = 1'b0;
    @(negedge clk);
    chk("cts_restart", {31'd0, idle}, 32'd0);
    recv(9, v);
    chk("cts_f2", 32'(v), 32'h1C3);
    repeat (bitc) @(negedge clk);

    // enable low holds frames
    enable = 1'b0;
    wr(9'h077);
    repeat (40) @(negedge clk);
    chk("en_hold_idle", {31'd0, idle}, 32'd1);
    chk("en_hold_cnt", 32'(bus.fifo_count_o), 32'd1);
    enable = 1'b1;
    recv(9, v);
    chk("en_frame", 32'(v), 32'h177);
    repeat (bitc) @(negedge clk);

    // flush beats a simultaneous write
    cts_n = 1'b1;
    wr(9'h001); wr(9'h002); wr(9'h003);
    chk("fl_pre_cnt", 32'(bus.fifo_count_o), 32'd3);
    d0 = ovf_cnt;
    bus.flush_i = 1'b1; bus.write_i = 1'b1; bus.data_i = 9'h004;
    @(negedge clk);
    bus.flush_i = 1'b0; bus.write_i = 1'b0;
    chk("fl_cnt", 32'(bus.fifo_count_o), 32'd0);
    chk("fl_empty", {31'd0, bus.fifo_empty_o}, 32'd1);
    @(negedge clk);
    chk("fl_no_ovf", 32'(ovf_cnt - d0), 32'd0);

    // reset mid-frame
    wr(9'h001); wr(9'h002);
    cts_n = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_busy", {31'd0, idle}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_cnt", 32'(bus.fifo_count_o), 32'd0);
    chk("mid_rst_idle", {31'd0, idle}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_idle", {31'd0, idle}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
